axi4_uart_tx_fifo_bridge: RTL and testbench

Parametrised successor to the SoC's fixed UART bridge. It is an AXI4 single-beat slave on the E-Class data port, decoding a 16-byte register window at BASE_ADDR. Bytes written to TXDATA are buffered in a FIFO of FIFO_DEPTH entries and serialised 8N1 at a compile-time baud rate. Unlike the previous bridge, it drives real ready/valid/response handshakes and provides a readable STATUS register.

---
 rtl/axi4_uart_tx_fifo_bridge.sv | 278 +++++++++++++++++++++++++++
 tb/tb_axi4_uart_tx_fifo_bridge.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_uart_tx_fifo_bridge.sv
`timescale 1ns/1ps
// AXI4 single-beat slave with a TX FIFO feeding an 8N1 UART serialiser.
// Window at BASE_ADDR: 0x0 TXDATA (W), 0x4 STATUS (R), 0x8/0xC reserved.
// Ports: CLK, RST_N (async, active-low), AXI4 AW/W/B/AR/R slave channels
// (s_*), uart_tx (idle high), uart_active (TX busy or FIFO non-empty).
// Optional macro UART_PARITY_EN adds an even-parity bit (11-bit frames)
// and sets STATUS bit3.
module axi4_uart_tx_fifo_bridge #(
   parameter int          CLK_HZ     = 12000000,
   parameter int          BAUD       = 115200,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
   parameter int          ID_W       = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            s_AWVALID,
   output logic            s_AWREADY,
   input  logic [31:0]     s_AWADDR,
   input  logic [ID_W-1:0] s_AWID,
   input  logic            s_WVALID,
   output logic            s_WREADY,
   input  logic [31:0]     s_WDATA,
   input  logic [3:0]      s_WSTRB,
   output logic            s_BVALID,
   input  logic            s_BREADY,
   output logic [1:0]      s_BRESP,
   output logic [ID_W-1:0] s_BID,
   input  logic            s_ARVALID,
   output logic            s_ARREADY,
   input  logic [31:0]     s_ARADDR,
   input  logic [ID_W-1:0] s_ARID,
   output logic            s_RVALID,
   input  logic            s_RREADY,
   output logic [31:0]     s_RDATA,
   output logic [1:0]      s_RRESP,
   output logic            s_RLAST,
   output logic [ID_W-1:0] s_RID,
   output logic            uart_tx,
   output logic            uart_active
);

   localparam int DIV   = CLK_HZ / BAUD;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = $clog2(DIV);
   localparam int DIVM1 = DIV - 1;
   localparam logic [AW:0]   FULL_LVL = FIFO_DEPTH[AW:0];
   localparam logic [AW:0]   PTR_ONE  = 1;
   localparam logic [CW-1:0] DIV_LAST = DIVM1[CW-1:0];
   localparam logic [CW-1:0] CNT_ONE  = 1;

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   tx_state_t tx_state, tx_next;

   logic            rst_done;
   logic [AW:0]     wptr, rptr, level;
   logic [7:0]      mem [FIFO_DEPTH];
   logic            fifo_full, fifo_empty, push, pop;
   logic            aw_hit, aw_push, wr_acc;
   logic            ar_hit, rd_acc, tx_busy, par_flag;
   logic [31:0]     status, rd_val;
   logic [ID_W-1:0] bid_q, rid_q;
   logic [1:0]      bresp_q, rresp_q;
   logic [31:0]     rdata_q;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            bit_end;
   logic            unused_ok;
`ifdef UART_PARITY_EN
   logic            par_bit;
`endif

   assign unused_ok = ^{s_WDATA[31:8], s_WSTRB[3:1],
                        s_AWADDR[1:0], s_ARADDR[1:0]};

   // FIFO occupancy from registered pointers only
   assign level      = wptr - rptr;
   assign fifo_full  = (level == FULL_LVL);
   assign fifo_empty = (level == '0);

   // Write channel
   assign aw_hit  = (s_AWADDR[31:4] == BASE_ADDR[31:4]);
   assign aw_push = aw_hit & (s_AWADDR[3:2] == 2'd0) & s_WSTRB[0];

   always_comb begin
      wr_next = wr_state;
      wr_acc  = 1'b0;
      case (wr_state)
         WR_IDLE:
            if (rst_done & s_AWVALID & s_WVALID
                & ~(aw_push & fifo_full)) begin
               wr_acc  = 1'b1;
               wr_next = WR_RESP;
            end
         WR_RESP:
            if (s_BREADY) wr_next = WR_IDLE;
         default: wr_next = WR_IDLE;
      endcase
   end

   assign s_AWREADY = wr_acc;
   assign s_WREADY  = wr_acc;
   assign s_BVALID  = (wr_state == WR_RESP);
   assign s_BRESP   = bresp_q;
   assign s_BID     = bid_q;
   assign push      = wr_acc & aw_push;

   // Read channel
`ifdef UART_PARITY_EN
   assign par_flag = 1'b1;
`else
   assign par_flag = 1'b0;
`endif
   assign tx_busy = (tx_state != TX_IDLE);
   assign status  = {16'd0, 8'(level), 4'd0,
                     par_flag, fifo_empty, fifo_full, tx_busy};
   assign ar_hit  = (s_ARADDR[31:4] == BASE_ADDR[31:4]);
   assign rd_val  = (ar_hit && s_ARADDR[3:2] == 2'd1) ? status : '0;

   always_comb begin
      rd_next = rd_state;
      rd_acc  = 1'b0;
      case (rd_state)
         RD_IDLE:
            if (rst_done & s_ARVALID) begin
               rd_acc  = 1'b1;
               rd_next = RD_RESP;
            end
         RD_RESP:
            if (s_RREADY) rd_next = RD_IDLE;
         default: rd_next = RD_IDLE;
      endcase
   end

   assign s_ARREADY = rst_done & (rd_state == RD_IDLE);
   assign s_RVALID  = (rd_state == RD_RESP);
   assign s_RDATA   = rdata_q;
   assign s_RRESP   = rresp_q;
   assign s_RID     = rid_q;
   assign s_RLAST   = 1'b1;

   // rst_done keeps every READY low while reset is held
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rst_done <= 1'b0;
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
         bid_q    <= '0;
         bresp_q  <= '0;
         rid_q    <= '0;
         rresp_q  <= '0;
         rdata_q  <= '0;
      end else begin
         rst_done <= 1'b1;
         wr_state <= wr_next;
         rd_state <= rd_next;
         if (wr_acc) begin
            bid_q   <= s_AWID;
            bresp_q <= aw_hit ? 2'b00 : 2'b11;
         end
         if (rd_acc) begin
            rid_q   <= s_ARID;
            rdata_q <= rd_val;
            rresp_q <= ar_hit ? 2'b00 : 2'b11;
         end
      end
   end

   // FIFO storage and pointers
   always_ff @(posedge CLK) begin
      if (push) mem[wptr[AW-1:0]] <= s_WDATA[7:0];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
      end
   end

   // TX serialiser
   assign bit_end = (baud_cnt == DIV_LAST);

   always_comb begin
      tx_next = tx_state;
      pop     = 1'b0;
      case (tx_state)
         TX_IDLE:
            if (!fifo_empty) begin
               pop     = 1'b1;
               tx_next = TX_START;
            end
         TX_START:
            if (bit_end) tx_next = TX_DATA;
         TX_DATA:
            if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
               tx_next = TX_PARITY;
`else
               tx_next = TX_STOP;
`endif
            end
`ifdef UART_PARITY_EN
         TX_PARITY:
            if (bit_end) tx_next = TX_STOP;
`endif
         TX_STOP:
            if (bit_end) begin
               // chain straight into the next start bit
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  tx_next = TX_START;
               end else begin
                  tx_next = TX_IDLE;
               end
            end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      uart_tx = 1'b1;
      case (tx_state)
         TX_START: uart_tx = 1'b0;
         TX_DATA:  uart_tx = shreg[0];
`ifdef UART_PARITY_EN
         TX_PARITY: uart_tx = par_bit;
`endif
         default:  uart_tx = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tx_state <= TX_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
`ifdef UART_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         tx_state <= tx_next;
         if (pop) begin
            shreg    <= mem[rptr[AW-1:0]];
`ifdef UART_PARITY_EN
            par_bit  <= ^mem[rptr[AW-1:0]];
`endif
            baud_cnt <= '0;
            bit_cnt  <= '0;
         end else if (tx_state != TX_IDLE) begin
            if (bit_end) begin
               baud_cnt <= '0;
               if (tx_state == TX_DATA) begin
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end else begin
               baud_cnt <= baud_cnt + CNT_ONE;
            end
         end
      end
   end

   assign uart_active = tx_busy | ~fifo_empty;

endmodule

// File: tb/tb_axi4_uart_tx_fifo_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for axi4_uart_tx_fifo_bridge (DIV=10, depth 4).
// Stimulus pushes expected B/R/UART results; monitors pop and compare.
module tb_axi4_uart_tx_fifo_bridge;

   localparam int DIV   = 10;
   localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int NB = 11;
   localparam logic [31:0] PBIT = 32'h8;
`else
   localparam int NB = 10;
   localparam logic [31:0] PBIT = 32'h0;
`endif
   localparam int FRAME = NB * DIV;
   localparam logic [31:0] BASE = 32'h9000_0000;

   logic        clk, rst_n;
   logic        awvalid, awready, wvalid, wready;
   logic [31:0] awaddr, wdata;
   logic [3:0]  awid, wstrb, bid, arid, rid;
   logic        bvalid, bready, arvalid, arready;
   logic [1:0]  bresp, rresp;
   logic [31:0] araddr, rdata;
   logic        rvalid, rready, rlast;
   logic        uart_tx, uart_active;

   axi4_uart_tx_fifo_bridge #(
      .CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH),
      .BASE_ADDR(BASE), .ID_W(4)
   ) dut (
      .CLK(clk), .RST_N(rst_n),
      .s_AWVALID(awvalid), .s_AWREADY(awready),
      .s_AWADDR(awaddr), .s_AWID(awid),
      .s_WVALID(wvalid), .s_WREADY(wready),
      .s_WDATA(wdata), .s_WSTRB(wstrb),
      .s_BVALID(bvalid), .s_BREADY(bready),
      .s_BRESP(bresp), .s_BID(bid),
      .s_ARVALID(arvalid), .s_ARREADY(arready),
      .s_ARADDR(araddr), .s_ARID(arid),
      .s_RVALID(rvalid), .s_RREADY(rready),
      .s_RDATA(rdata), .s_RRESP(rresp),
      .s_RLAST(rlast), .s_RID(rid),
      .uart_tx(uart_tx), .uart_active(uart_active)
   );

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_t;
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
   } r_t;

   b_t         bq[$];
   r_t         rq[$];
   logic [7:0] uq[$];
   int         fstart[$];
   int         checks, errors, cyc, ready_mode, dummy;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever @(posedge clk) cyc++;
   end

   task automatic chk(input bit ok, input string name,
                      input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      return (a & 32'hFFFF_FFF0) == BASE;
   endfunction

   // BREADY/RREADY driver: 0 always, 1 random, 2 held low
   initial begin
      bready = 0;
      rready = 0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: begin bready = 1; rready = 1; end
            1: begin
               bready = ($urandom_range(0, 3) != 0);
               rready = ($urandom_range(0, 3) != 0);
            end
            default: begin bready = 0; rready = 0; end
         endcase
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] st, input logic [3:0] id,
                     output int waited);
      b_t e;
      bit ok;
      waited = 0;
      ok = 0;
      @(posedge clk);
      #1;
      awvalid = 1; awaddr = a; awid = id;
      wvalid = 1; wdata = d; wstrb = st;
      forever begin
         @(negedge clk);
         if (awready != wready)
            chk(0, "aw_w_ready_pair", {awready, wready}, 2'b00);
         if (awready && wready) begin ok = 1; break; end
         waited++;
         if (waited > 3000) begin
            chk(0, "wr_timeout", waited, 3000);
            break;
         end
      end
      if (ok) begin
         e.id = id;
         e.resp = in_win(a) ? 2'b00 : 2'b11;
         bq.push_back(e);
         if (in_win(a) && a[3:0] == 4'h0 && st[0]) uq.push_back(d[7:0]);
      end
      @(posedge clk);
      #1;
      awvalid = 0;
      wvalid = 0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [3:0] id,
                     input logic [31:0] exp_data);
      r_t e;
      int waited;
      waited = 0;
      @(posedge clk);
      #1;
      arvalid = 1; araddr = a; arid = id;
      forever begin
         @(negedge clk);
         if (arready) break;
         waited++;
         if (waited > 3000) begin
            chk(0, "rd_timeout", waited, 3000);
            break;
         end
      end
      if (arready) begin
         e.id = id;
         e.resp = in_win(a) ? 2'b00 : 2'b11;
         e.data = in_win(a) ? exp_data : 32'h0;
         rq.push_back(e);
      end
      @(posedge clk);
      #1;
      arvalid = 0;
   endtask

   // B monitor
   initial begin
      logic pv, pr;
      logic [1:0] presp;
      logic [3:0] pid;
      b_t e;
      pv = 0; pr = 0; presp = 0; pid = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin pv = 0; continue; end
         if (pv && !pr)
            chk(bvalid && bresp == presp && bid == pid, "b_stable",
                {bvalid, bid, bresp}, {1'b1, pid, presp});
         if (bvalid) chk(!awready, "aw_blocked", awready, 0);
         if (bvalid && bready) begin
            if (bq.size() == 0) chk(0, "b_unexpected", {bid, bresp}, 0);
            else begin
               e = bq.pop_front();
               chk(bid == e.id && bresp == e.resp, "b_resp",
                   {bid, bresp}, {e.id, e.resp});
            end
         end
         pv = bvalid; pr = bready; presp = bresp; pid = bid;
      end
   end

   // R monitor
   initial begin
      logic pv, pr;
      logic [1:0] presp;
      logic [3:0] pid;
      logic [31:0] pdata;
      r_t e;
      pv = 0; pr = 0; presp = 0; pid = 0; pdata = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin pv = 0; continue; end
         if (pv && !pr)
            chk(rvalid && rresp == presp && rid == pid && rdata == pdata,
                "r_stable", {rvalid, rid, rresp, rdata},
                {1'b1, pid, presp, pdata});
         if (rvalid) chk(!arready, "ar_blocked", arready, 0);
         if (rvalid && rready) begin
            if (rq.size() == 0) chk(0, "r_unexpected", rdata, 0);
            else begin
               e = rq.pop_front();
               chk(rid == e.id && rresp == e.resp && rdata == e.data && rlast,
                   "r_resp", {rlast, rid, rresp, rdata},
                   {1'b1, e.id, e.resp, e.data});
            end
         end
         pv = rvalid; pr = rready; presp = rresp; pid = rid; pdata = rdata;
      end
   end

   // UART receiver: every bit must hold for exactly DIV cycles
   initial begin
      logic prev, abort, ok;
      logic samp [FRAME];
      logic [NB-1:0] bits;
      logic [7:0] dat, e;
      int sc;
      prev = 1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin prev = 1; continue; end
         if (prev && !uart_tx) begin
            sc = cyc;
            abort = 0;
            samp[0] = uart_tx;
            for (int k = 1; k < FRAME; k++) begin
               @(negedge clk);
               if (!rst_n) begin abort = 1; break; end
               samp[k] = uart_tx;
            end
            prev = 1;
            if (abort) continue;
            ok = 1;
            for (int b = 0; b < NB; b++) begin
               bits[b] = samp[b*DIV];
               for (int j = 1; j < DIV; j++)
                  if (samp[b*DIV+j] != bits[b]) ok = 0;
            end
            dat = bits[8:1];
            if (bits[0] != 1'b0 || bits[NB-1] != 1'b1) ok = 0;
`ifdef UART_PARITY_EN
            if (bits[9] != ^dat) ok = 0;
`endif
            fstart.push_back(sc);
            if (uq.size() == 0) chk(0, "uart_unexpected", bits, 0);
            else begin
               e = uq.pop_front();
               chk(ok && dat == e, "uart_frame", {ok, dat}, {1'b1, e});
            end
            prev = samp[FRAME-1];
         end else begin
            prev = uart_tx;
         end
      end
   end

   task automatic wait_low(output bit seen);
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!uart_tx) begin seen = 1; break; end
      end
      if (!seen) chk(0, "start_timeout", uart_tx, 0);
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((uq.size() != 0 || uart_active) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) chk(0, "idle_timeout", uq.size(), 0);
   endtask

   initial begin
      int w, n0;
      bit seen;
      logic [31:0] a;
      logic [3:0] st;
      checks = 0; errors = 0; ready_mode = 0; dummy = 0;
      rst_n = 0;
      awvalid = 0; awaddr = 0; awid = 0;
      wvalid = 0; wdata = 0; wstrb = 0;
      arvalid = 0; araddr = 0; arid = 0;

      // reset state
      repeat (3) @(negedge clk);
      chk(uart_tx == 1 && !uart_active, "rst_uart", {uart_tx, uart_active}, 2'b10);
      chk(!(awready | wready | arready | bvalid | rvalid), "rst_hs",
          {awready, wready, arready, bvalid, rvalid}, 0);
      chk(bresp == 0 && rresp == 0 && rdata == 0 && bid == 0 && rid == 0,
          "rst_regs", {bresp, rresp, bid, rid, rdata}, 0);
      @(posedge clk);
      #1 rst_n = 1;
      rd(BASE + 4, 4'h1, 32'h4 | PBIT);

      // single byte 0x55
      wr(BASE, 32'h55, 4'h1, 4'h2, w);
      chk(w == 0, "wr_first_cycle", w, 0);
      @(negedge clk);
      chk(bvalid && bresp == 0 && !awready, "b_next_cycle",
          {bvalid, bresp, awready}, 4'b1000);
      wait_low(seen);
      repeat (FRAME - 1) @(negedge clk);
      chk(uart_active, "active_in_stop", uart_active, 1);
      @(negedge clk);
      chk(!uart_active && uart_tx, "active_falls",
          {uart_active, uart_tx}, 2'b01);

      // burst fills the FIFO; sixth write stalls
      n0 = fstart.size();
      for (int i = 1; i <= 5; i++) wr(BASE, i, 4'h1, 4'(i), w);
      rd(BASE + 4, 4'h9, 32'h0403 | PBIT);
      wr(BASE, 32'h6, 4'h1, 4'h6, w);
      chk(w > FRAME / 2, "full_stall", w, FRAME / 2);
      wait_idle(10 * FRAME);
      for (int k = 0; k < 5; k++)
         chk(fstart.size() > n0 + k + 1 &&
             fstart[n0+k+1] - fstart[n0+k] == FRAME, "no_gap",
             (fstart.size() > n0 + k + 1) ? fstart[n0+k+1] - fstart[n0+k] : -1,
             FRAME);

      // decode errors
      wr(32'h9000_0010, 32'h77, 4'h1, 4'h3, w);
      rd(32'h8000_0000, 4'hA, 32'h0);
      rd(BASE + 4, 4'h2, 32'h4 | PBIT);
      repeat (3) @(negedge clk);
      chk(!uart_active, "decerr_no_push", uart_active, 0);

      // held BREADY / RREADY
      ready_mode = 2;
      @(posedge clk);
      wr(BASE + 8, 32'h12, 4'hF, 4'h5, w);
      fork wr(BASE + 12, 32'h34, 4'hF, 4'h6, dummy); join_none
      repeat (5) @(negedge clk);
      chk(bvalid && bid == 5 && bresp == 0 && !awready, "b_hold",
          {bvalid, bid, bresp, awready}, {1'b1, 4'h5, 2'b00, 1'b0});
      ready_mode = 0;
      wait fork;
      ready_mode = 2;
      @(posedge clk);
      rd(BASE + 8, 4'h7, 32'h0);
      fork rd(32'h1234_5678, 4'h8, 32'h0); join_none
      repeat (5) @(negedge clk);
      chk(rvalid && rid == 7 && rresp == 0 && !arready, "r_hold",
          {rvalid, rid, rresp, arready}, {1'b1, 4'h7, 2'b00, 1'b0});
      ready_mode = 0;
      wait fork;

      // randomized traffic
      ready_mode = 1;
      for (int n = 0; n < 120; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 4) a = BASE;
         else if (kind < 6) a = BASE + 32'(4 * $urandom_range(1, 3));
         else begin
            a = $urandom;
            if (in_win(a)) a = a ^ 32'h1000_0000;
         end
         if ($urandom_range(0, 9) < 6) begin
            st = 4'($urandom_range(0, 15));
            wr(a, $urandom, st, 4'($urandom_range(0, 15)), w);
         end else begin
            if (a[3:0] == 4'h4 && in_win(a)) a = BASE + 8;
            rd(a, 4'($urandom_range(0, 15)), 32'h0);
         end
      end
      ready_mode = 0;
      wait_idle(12000);
      repeat (4) @(negedge clk);
      chk(bq.size() == 0 && rq.size() == 0 && uq.size() == 0, "drain",
          {bq.size(), rq.size(), uq.size()}, 0);

      // reset mid-frame
      wr(BASE, 32'h3C, 4'h1, 4'h1, w);
      wr(BASE, 32'hA5, 4'h1, 4'h2, w);
      wr(BASE, 32'h0F, 4'h1, 4'h3, w);
      wait_low(seen);
      repeat (DIV + 3) @(negedge clk);
      chk(!uart_tx, "data_bit0_low", uart_tx, 0);
      #2 rst_n = 0;
      #1;
      chk(uart_tx && !uart_active, "rst_async_tx",
          {uart_tx, uart_active}, 2'b10);
      uq.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      rd(BASE + 4, 4'h4, 32'h4 | PBIT);
      repeat (30) @(negedge clk);
      chk(uart_tx && !uart_active, "fifo_discarded",
          {uart_tx, uart_active}, 2'b10);
      repeat (4) @(negedge clk);
      chk(rq.size() == 0 && bq.size() == 0, "final_queues",
          {rq.size(), bq.size()}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
